flash_boot_loader: RTL
======================

// Module: flash_boot_loader
// PURPOSE
//  Boot-time copier that sits between the flash read controller (upstream) and the
//  instruction-SRAM wrapper (downstream). Fetches 16-bit halfwords from flash, packs
//  pairs into byte-reversed 32-bit words, and writes them to SRAM from BASE_ADDR.
//  Holds the CPU in reset for the whole copy and signals completion.
// PARAMETERS
//  WORD_COUNT   1048576   32-bit words to copy (4 MiB image); must be >= 1
//  FLASH_AW     22        flash halfword address width
//  BASE_ADDR    32'h0     byte address of the first SRAM word
//  WR_CYCLES    2         cycles ram_we_o is held per word (async SRAM timing); >= 1
// PORTS
//  clk            in   1         system clock
//  rst            in   1         synchronous, active-high reset
//  start_i        in   1         start/restart copy; sampled in IDLE and DONE only
//  flash_req_o    out  1         read request to flash controller
//  flash_addr_o   out  FLASH_AW  halfword address of the request
//  flash_ready_i  in   1         flash data valid (level, may stay high several cycles)
//  flash_data_i   in   16        halfword read data
//  ram_ce_o       out  1         SRAM chip enable (active high)
//  ram_we_o       out  1         SRAM write enable (active high)
//  ram_addr_o     out  32        SRAM byte address
//  ram_data_o     out  32        SRAM write data
//  ram_sel_o      out  4         byte selects; always 4'b1111 while ram_ce_o
//  busy_o         out  1         copy in progress
//  done_o         out  1         copy finished, image valid
//  cpu_rst_o      out  1         CPU reset request
//  progress_o     out  16        words written [15:0], for LEDs
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; ram_sel_o 0; word/halfword counters 0. Reset
//   mid-copy aborts immediately; no write completes after the reset cycle.
//  States: IDLE, RD_REL, RD_REQ, WR, DONE.
//  IDLE/DONE: start_i=1 -> clear counters, go RD_REL. start_i during RD_*/WR ignored.
//  RD_REL: flash_req_o=0; wait for flash_ready_i=0 (rejects stale or held-over ready),
//   then RD_REQ. Entered also before every halfword.
//  RD_REQ: flash_req_o=1, flash_addr_o = 2*word_idx + hw_sel. On first cycle with
//   flash_ready_i=1 capture flash_data_i: hw_sel=0 -> hi reg, next RD_REL;
//   hw_sel=1 -> lo reg, go WR. Exactly one capture per request.
//  Packing: {hi,lo} byte-reversed: ram_data_o = {lo[7:0],lo[15:8],hi[7:0],hi[15:8]}.
//  WR: ram_ce_o=ram_we_o=1 for exactly WR_CYCLES cycles; ram_addr_o =
//   BASE_ADDR + 4*word_idx (32-bit wrap); data/addr stable for the whole strobe.
//   Then word_idx++; if word_idx == WORD_COUNT -> DONE else RD_REL.
//  DONE: done_o=1, busy_o=0; all RAM/flash outputs 0.
//  busy_o = 1 in RD_REL/RD_REQ/WR. cpu_rst_o = busy_o OR first DONE cycle (one
//   extra cycle so the CPU leaves reset after the last write settles).
//  progress_o = word_idx[15:0] (wraps at 65536; informative only).
//  Latency per word: 2 flash handshakes + WR_CYCLES + 2 RD_REL visits (min 1 cycle each).
// CONFIGURATION
//  FLASH_BOOT_CHECKSUM_EN defined: adds output checksum_o[31:0], modulo-2^32 sum of every
//   written ram_data_o, cleared on rst and on start; valid when done_o=1. Also adds
//   input expect_i[31:0]; done_o asserts only if checksum_o==expect_i, else DONE
//   with new output err_o=1 and cpu_rst_o held high until next start/rst.
//  Not defined: no checksum logic, ports absent, DONE entered unconditionally.
// STRUCTURE
//  Shared package/header (defines.vh): state encodings, WORD_COUNT default,
//   reverse_endian function. One natural sub-module: flash_boot_packer (hi/lo
//   registers + byte reversal + optional checksum accumulator). FSM stays in top.
// TESTING (bench: WORD_COUNT=4, WR_CYCLES=2, BASE_ADDR=32'h100)
//  1 Flash model returns hw(a)=16'hA000+a, 3-cycle ready -> word0 at 0x100 = 32'h01A000A0,
//    word3 at 0x10C = 32'h07A006A0; done_o after 4th write; 4 writes total.
//  2 flash_ready_i held high 5 cycles per read -> one capture per request, 8 reads total,
//    addresses 0..7 strictly increasing.
//  3 flash_ready_i=1 already at start -> no capture until it drops; first addr is 0.
//  4 rst asserted during WR of word 2 -> next cycle all outputs 0, IDLE; restart via start_i
//    copies all 4 words again from addr 0.
//  5 start_i pulsed while busy -> ignored; cpu_rst_o high throughout copy and 1 cycle into DONE.
//  6 FLASH_BOOT_CHECKSUM_EN, expect_i = correct sum -> done_o=1; expect_i off by 1 ->
//    err_o=1, done_o=0, cpu_rst_o stays 1.

Source files
------------

// File: rtl/flash_boot_loader_pkg.sv
// rtl/flash_boot_loader_pkg.sv - shared state encoding, defaults and byte-reversal helper for the flash boot loader
package flash_boot_loader_pkg;

    localparam int unsigned WORD_COUNT_DEFAULT = 1048576;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_REL = 3'd1,
        ST_RD_REQ = 3'd2,
        ST_WR     = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Flash stores the image big-endian per halfword pair; the CPU wants little-endian words.
    function automatic logic [31:0] reverse_endian(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/flash_boot_packer.sv
// rtl/flash_boot_packer.sv - halfword pair registers, byte-reversed word packing, optional checksum (FLASH_BOOT_CHECKSUM_EN)
module flash_boot_packer
    import flash_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cap_hi,
    input  logic        cap_lo,
    input  logic [15:0] data,
`ifdef FLASH_BOOT_CHECKSUM_EN
    input  logic        clear,
    input  logic        acc,
    output logic [31:0] checksum,
`endif
    output logic [31:0] word
);

    logic [15:0] hi;
    logic [15:0] lo;

    // Capture the even halfword into hi and the odd halfword into lo.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (cap_hi) hi <= data;
            if (cap_lo) lo <= data;
        end
    end

    assign word = reverse_endian({hi, lo});

`ifdef FLASH_BOOT_CHECKSUM_EN
    // Running modulo-2^32 sum of every word written, restarted with each copy.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            checksum <= '0;
        end else if (acc) begin
            checksum <= checksum + word;
        end
    end
`endif

endmodule

// File: rtl/flash_boot_loader.sv
// rtl/flash_boot_loader.sv - boot copier from flash to instruction SRAM holding the CPU in reset; option FLASH_BOOT_CHECKSUM_EN
module flash_boot_loader
    import flash_boot_loader_pkg::*;
#(
    parameter int unsigned WORD_COUNT = WORD_COUNT_DEFAULT,
    parameter int unsigned FLASH_AW   = 22,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int unsigned WR_CYCLES  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    output logic                flash_req_o,
    output logic [FLASH_AW-1:0] flash_addr_o,
    input  logic                flash_ready_i,
    input  logic [15:0]         flash_data_i,
    output logic                ram_ce_o,
    output logic                ram_we_o,
    output logic [31:0]         ram_addr_o,
    output logic [31:0]         ram_data_o,
    output logic [3:0]          ram_sel_o,
`ifdef FLASH_BOOT_CHECKSUM_EN
    input  logic [31:0]         expect_i,
    output logic [31:0]         checksum_o,
    output logic                err_o,
`endif
    output logic                busy_o,
    output logic                done_o,
    output logic                cpu_rst_o,
    output logic [15:0]         progress_o
);

    localparam logic [7:0]  WR_LAST  = 8'(WR_CYCLES - 1);
    localparam logic [31:0] IDX_LAST = 32'(WORD_COUNT - 1);

    state_t      state;
    state_t      state_next;
    logic [31:0] word_idx;
    logic        hw_sel;
    logic [7:0]  wr_cnt;
    logic        busy_q;
    logic        busy;
    logic        start_copy;
    logic        cap;
    logic        wr_last;
    logic        word_last;
    logic        fail;
    logic [31:0] word;

    assign busy       = (state == ST_RD_REL) || (state == ST_RD_REQ) || (state == ST_WR);
    assign start_copy = ((state == ST_IDLE) || (state == ST_DONE)) && start_i;
    assign cap        = (state == ST_RD_REQ) && flash_ready_i;
    assign wr_last    = (state == ST_WR) && (wr_cnt == WR_LAST);
    assign word_last  = (word_idx == IDX_LAST);

    flash_boot_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .cap_hi   (cap && !hw_sel),
        .cap_lo   (cap && hw_sel),
        .data     (flash_data_i),
`ifdef FLASH_BOOT_CHECKSUM_EN
        .clear    (start_copy),
        .acc      (wr_last),
        .checksum (checksum_o),
`endif
        .word     (word)
    );

`ifdef FLASH_BOOT_CHECKSUM_EN
    assign fail  = (state == ST_DONE) && (checksum_o != expect_i);
    assign err_o = fail;
`else
    assign fail  = 1'b0;
`endif

    // State register plus word/halfword/strobe counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            word_idx <= '0;
            hw_sel   <= 1'b0;
            wr_cnt   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= busy;
            if (start_copy) begin
                word_idx <= '0;
                hw_sel   <= 1'b0;
                wr_cnt   <= '0;
            end else begin
                if (cap) hw_sel <= ~hw_sel;
                if (state == ST_WR) begin
                    if (wr_last) begin
                        wr_cnt   <= '0;
                        word_idx <= word_idx + 32'd1;
                    end else begin
                        wr_cnt <= wr_cnt + 8'd1;
                    end
                end
            end
        end
    end

    // Next-state decode and Moore outputs; RAM/flash buses are zero outside their states.
    always_comb begin
        state_next   = state;
        flash_req_o  = 1'b0;
        flash_addr_o = '0;
        ram_ce_o     = 1'b0;
        ram_we_o     = 1'b0;
        ram_addr_o   = '0;
        ram_data_o   = '0;
        ram_sel_o    = '0;
        busy_o       = busy;
        done_o       = (state == ST_DONE) && !fail;
        // One extra DONE cycle keeps the CPU in reset while the last write settles.
        cpu_rst_o    = busy || ((state == ST_DONE) && busy_q) || fail;
        progress_o   = word_idx[15:0];
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_i) state_next = ST_RD_REL;
            end
            ST_RD_REL: begin
                if (!flash_ready_i) state_next = ST_RD_REQ;
            end
            ST_RD_REQ: begin
                flash_req_o  = 1'b1;
                flash_addr_o = {word_idx[FLASH_AW-2:0], hw_sel};
                if (flash_ready_i) state_next = hw_sel ? ST_WR : ST_RD_REL;
            end
            ST_WR: begin
                ram_ce_o   = 1'b1;
                ram_we_o   = 1'b1;
                ram_sel_o  = 4'b1111;
                ram_addr_o = BASE_ADDR + {word_idx[29:0], 2'b00};
                ram_data_o = word;
                if (wr_last) state_next = word_last ? ST_DONE : ST_RD_REL;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
